// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 constants and op encodings
package fp_pkg;

  localparam int          FP32_W        = 32;
  localparam int          FP32_SIGN_BIT = 31;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_PASS_A = 2'b01,
    OP_PASS_B = 2'b10,
    OP_SUB    = 2'b11
  } fp_op_e;

endpackage

// File: rtl/fp32adder.sv
// rtl/fp32adder.sv - combinational FP32 adder, round-to-nearest-even, denormals kept
module fp32adder
  import fp_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap, eff_sub, sign, found, rnd;
  logic [31:0] l, s;
  logic [7:0]  el_eff, es_eff, d;
  logic [23:0] ml, ms;
  logic [26:0] ext_l, ext_s, sh_s, back, n_n;
  logic [27:0] sum;
  logic [9:0]  e_w, e_n, sh;
  logic [4:0]  lz;
  logic [24:0] mant;
  logic [32:0] mag;

  // Align, add/subtract magnitudes, normalise and round the larger-magnitude result
  always_comb begin
    a_nan   = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
    b_nan   = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
    a_inf   = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
    b_inf   = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);

    // Order operands by magnitude so the subtraction never goes negative
    swap    = b_i[30:0] > a_i[30:0];
    l       = swap ? b_i : a_i;
    s       = swap ? a_i : b_i;
    sign    = l[31];
    eff_sub = l[31] ^ s[31];

    // Denormals use exponent 1 without the hidden bit
    el_eff  = (l[30:23] == 8'd0) ? 8'd1 : l[30:23];
    es_eff  = (s[30:23] == 8'd0) ? 8'd1 : s[30:23];
    ml      = {(l[30:23] != 8'd0), l[22:0]};
    ms      = {(s[30:23] != 8'd0), s[22:0]};
    d       = el_eff - es_eff;

    // Three extra bits (guard, round, sticky) below the mantissa
    ext_l   = {ml, 3'b000};
    ext_s   = {ms, 3'b000};
    sh_s    = ext_s >> d;
    back    = sh_s << d;
    if (back != ext_s) begin
      sh_s[0] = 1'b1;
    end

    sum     = eff_sub ? ({1'b0, ext_l} - {1'b0, sh_s}) : ({1'b0, ext_l} + {1'b0, sh_s});
    e_w     = {2'b00, el_eff};

    lz      = 5'd27;
    found   = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
        lz    = 5'(26 - i);
      end
    end

    sh      = '0;
    if (sum[27]) begin
      // Carry out: shift right one, folding the lost bit into sticky
      n_n    = sum[27:1];
      n_n[0] = sum[1] | sum[0];
      e_n    = e_w + 10'd1;
    end else begin
      // Left shift stops at exponent 1, leaving a denormal when it must
      sh     = ({5'd0, lz} < (e_w - 10'd1)) ? {5'd0, lz} : (e_w - 10'd1);
      n_n    = sum[26:0] << sh;
      e_n    = e_w - sh;
    end

    rnd     = n_n[2] & (n_n[1] | n_n[0] | n_n[3]);
    mant    = {1'b0, n_n[26:3]} + 25'(rnd);
    // Hidden bit and mantissa carry ripple straight into the exponent field
    mag     = ((33'(e_n) - 33'd1) << 23) + 33'(mant);

    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] ^ b_i[31]))) begin
      y_o = FP32_QNAN;
    end else if (a_inf) begin
      y_o = a_i;
    end else if (b_inf) begin
      y_o = b_i;
    end else if (sum == 28'd0) begin
      y_o = {(~eff_sub) & sign, 31'd0};
    end else if (mag >= 33'h0_7F80_0000) begin
      y_o = {sign, 8'hFF, 23'd0};
    end else begin
      y_o = {sign, mag[30:0]};
    end
  end

endmodule

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter, search starts at ptr
module rr_arb #(
  parameter int N = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic            found;
  logic [ID_W-1:0] sel;

  // First set request at or after ptr, wrapping modulo N
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sel      = '0;
    for (int k = 0; k < N; k++) begin
      sel = ID_W'((int'(ptr) + k) % N);
      if (!found && req[sel]) begin
        found       = 1'b1;
        grant[sel]  = 1'b1;
        grant_id    = sel;
      end
    end
  end

endmodule

// File: rtl/fp32_add_arbiter.sv
// rtl/fp32_add_arbiter.sv - round-robin sharing of one FP32 adder with a one-entry response slot
module fp32_add_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*FP32_W-1:0] req_a,
  input  logic [N_REQ*FP32_W-1:0] req_b,
  input  logic [N_REQ*2-1:0]      req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP32_W-1:0]       rsp_data
);

  logic [FP32_W-1:0] a_arr [N_REQ];
  logic [FP32_W-1:0] b_arr [N_REQ];
  fp_op_e            op_arr [N_REQ];

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   gid;
  logic              slot_free, xfer;
  logic [FP32_W-1:0] a_sel, b_sel, b_add, sum, op_result;
  fp_op_e            op_sel;

  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [FP32_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  // Split the packed per-requester buses into arrays
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i]  = req_a[i*FP32_W +: FP32_W];
      b_arr[i]  = req_b[i*FP32_W +: FP32_W];
      op_arr[i] = fp_op_e'(req_op[i*2 +: 2]);
    end
  end

  rr_arb #(.N(N_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (gid)
  );

  // A full slot can be refilled in the same edge it is drained
  always_comb begin
    slot_free = ~rsp_valid_q | rsp_ready;
    req_ready = rst ? '0 : (grant & {N_REQ{slot_free}});
    xfer      = |(req_valid & req_ready);
  end

  // Operand and op selection for the granted requester; subtract flips B's sign
  always_comb begin
    a_sel = a_arr[gid];
    b_sel = b_arr[gid];
    op_sel = op_arr[gid];
    b_add = b_sel;
    if (op_sel == OP_SUB) begin
      b_add = {~b_sel[FP32_SIGN_BIT], b_sel[FP32_SIGN_BIT-1:0]};
    end
  end

  fp32adder u_add (
    .a_i (a_sel),
    .b_i (b_add),
    .y_o (sum)
  );

  // Pass ops forward the operand bit-exact, bypassing the adder
  always_comb begin
    case (op_sel)
      OP_PASS_A: op_result = a_sel;
      OP_PASS_B: op_result = b_sel;
      default:   op_result = sum;
    endcase
  end

  // Response slot and pointer next state
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gid;
      rsp_data_d  = op_result;
      ptr_d       = (gid == ID_W'(N_REQ - 1)) ? '0 : gid + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// tb/tb_fp32_add_arbiter.sv - randomized bench with real-arithmetic reference model
module tb_fp32_add_arbiter;
  import fp_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N*2-1:0] req_op = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid = 0;
  int          m_id    = 0;
  logic [31:0] m_data  = '0;
  int          m_ptr   = 0;

  logic [31:0] pool [10] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                             32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h807F_FFFF,
                             32'h7F7F_FFFF, 32'h0080_0000};

  fp32_add_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    real m;
    int  ex;
    ex = int'(x[30:23]);
    if (ex == 0) m = real'(int'(x[22:0])) * (2.0 ** (-149));
    else         m = real'(int'({1'b1, x[22:0]})) * (2.0 ** (ex - 150));
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d, sig, keep, rem, half, mag;
    int e, shift, base;
    d = $realtobits(v);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e   = int'(d[62:52]) - 1023;
    sig = {11'd0, 1'b1, d[51:0]};
    if (e >= -126) begin base = e + 126; shift = 29; end
    else begin base = 0; shift = 29 + (-126 - e); end
    if (shift > 60) keep = '0;
    else begin
      keep = sig >> shift;
      rem  = sig & ((64'd1 << shift) - 64'd1);
      half = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
    end
    mag = (64'(base) << 23) + keep;
    if (mag >= 64'h7F80_0000) return {d[63], 31'h7F80_0000};
    return {d[63], mag[30:0]};
  endfunction

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction

  function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bb;
    if (op == 2'b01) return a;
    if (op == 2'b10) return b;
    bb = (op == 2'b11) ? (b ^ 32'h8000_0000) : b;
    if (is_nan(a) || is_nan(bb)) return 32'h7FC0_0000;
    if (is_inf(a) && is_inf(bb)) return (a[31] != bb[31]) ? 32'h7FC0_0000 : a;
    if (is_inf(a)) return a;
    if (is_inf(bb)) return bb;
    return r2f(f2r(a) + f2r(bb));
  endfunction

  function automatic logic [31:0] rand_fp();
    case ($urandom_range(0, 9))
      6, 7:    return pool[$urandom_range(0, 9)];
      8:       return $urandom;
      9:       return {1'($urandom), 8'($urandom_range(0, 1)), 23'($urandom)};
      default: return {1'($urandom), 8'($urandom_range(115, 140)), 23'($urandom)};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[2*i +: 2] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // Reference model: compares every cycle at the falling edge, advances on the rising edge
  initial begin : model
    logic [N-1:0] exp_ready;
    int g, nid, nptr, idx;
    bit nv;
    logic [31:0] nd;
    forever begin
      @(negedge clk);
      if (rst) begin m_valid = 0; m_id = 0; m_data = '0; m_ptr = 0; end
      exp_ready = '0;
      g = -1;
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0 && (!m_valid || rsp_ready)) exp_ready[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_id", 32'(rsp_id), m_id);
      chk("rsp_data", rsp_data, m_data);
      nv = m_valid; nid = m_id; nd = m_data; nptr = m_ptr;
      if (exp_ready != '0) begin
        nv = 1; nid = g; nptr = (g + 1) % N;
        nd = model_op(req_op[2*g +: 2], req_a[32*g +: 32], req_b[32*g +: 32]);
      end else if (rsp_ready) begin
        nv = 0;
      end
      @(posedge clk or posedge rst);
      if (rst) begin m_valid = 0; m_id = 0; m_data = '0; m_ptr = 0; end
      else begin m_valid = nv; m_id = nid; m_data = nd; m_ptr = nptr; end
    end
  end

  initial begin : stim
    logic [N-1:0] acc;
    logic [31:0] ta, tb;

    // Hand-computed values pinning the reference model
    chk("model_add",     model_op(2'b00, 32'h3F80_0000, 32'h4000_0000), 32'h4040_0000);
    chk("model_sub",     model_op(2'b11, 32'h4040_0000, 32'h3F80_0000), 32'h4000_0000);
    chk("model_pass",    model_op(2'b01, 32'h7FC0_0001, 32'h0000_0000), 32'h7FC0_0001);
    chk("model_tie",     model_op(2'b00, 32'h3F80_0000, 32'h3380_0000), 32'h3F80_0000);
    chk("model_above",   model_op(2'b00, 32'h3F80_0000, 32'h3380_0001), 32'h3F80_0001);
    chk("model_ovf",     model_op(2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF), 32'h7F80_0000);
    chk("model_cancel",  model_op(2'b11, 32'h3F80_0000, 32'h3F80_0000), 32'h0000_0000);
    chk("model_negzero", model_op(2'b00, 32'h8000_0000, 32'h8000_0000), 32'h8000_0000);
    chk("model_denorm",  model_op(2'b00, 32'h0000_0001, 32'h0000_0001), 32'h0000_0002);
    chk("model_infinf",  model_op(2'b00, 32'h7F80_0000, 32'hFF80_0000), 32'h7FC0_0000);

    // Reset state, with requests already pending
    req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 32'h3F80_0000, 32'h3F80_0000);
    step(); step();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_id",    32'(rsp_id), 32'h0);
    chk("rst_data",  rsp_data, 32'h0);
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Fairness: all valid, grants rotate 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_onehot", 32'($countones(req_ready)), 32'd1);
      chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      chk("fair_id", 32'(rsp_id), 32'(k % 4));
    end

    // Add on requester 0
    req_valid = 4'b0001;
    set_req(0, 2'b00, 32'h3F80_0000, 32'h4000_0000);
    step();
    chk("add_valid", 32'(rsp_valid), 32'h1);
    chk("add_id", 32'(rsp_id), 32'h0);
    chk("add_data", rsp_data, 32'h4040_0000);

    // Subtract on requester 2
    req_valid = 4'b0100;
    set_req(2, 2'b11, 32'h4040_0000, 32'h3F80_0000);
    step();
    chk("sub_id", 32'(rsp_id), 32'h2);
    chk("sub_data", rsp_data, 32'h4000_0000);

    // Pass A on requester 1 keeps the NaN payload
    req_valid = 4'b0010;
    set_req(1, 2'b01, 32'h7FC0_0001, 32'h1234_5678);
    step();
    chk("pass_id", 32'(rsp_id), 32'h1);
    chk("pass_data", rsp_data, 32'h7FC0_0001);

    // Sparse requests wrap the pointer
    req_valid = 4'b1000;
    step();
    chk("sparse3_id", 32'(rsp_id), 32'h3);
    req_valid = 4'b0001;
    step();
    chk("sparse0_id", 32'(rsp_id), 32'h0);

    // Backpressure with a full slot
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      step();
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_id", 32'(rsp_id), 32'h0);
      chk("bp_data", rsp_data, 32'h4040_0000);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(req_ready), 32'b0010);
    step();
    chk("bp_release_id", 32'(rsp_id), 32'h1);
    chk("bp_release_data", rsp_data, 32'h7FC0_0001);

    // Asynchronous reset while the slot is full
    rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'h0);
    chk("arst_data", rsp_data, 32'h0);
    chk("arst_id", 32'(rsp_id), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("arst_first_grant", 32'(req_ready), 32'b0001);
    step();
    chk("arst_first_id", 32'(rsp_id), 32'h0);
    chk("arst_first_data", rsp_data, 32'h4040_0000);

    // Randomized traffic; requesters hold requests until accepted
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          ta = rand_fp();
          tb = rand_fp();
          if ($urandom_range(0, 5) == 0) tb = ta ^ 32'($urandom_range(0, 7)) ^ {1'($urandom), 31'd0};
          set_req(i, 2'($urandom_range(0, 3)), ta, tb);
        end else if ($urandom_range(0, 63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 4) != 0);
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_add_arbiter.md
# fp32_add_arbiter

- Shares one combinational `fp32adder` instance between `N_REQ` requesters.
- Selects one requester per cycle by round-robin, then applies that requester's operation: sum, pass A, pass B, or subtract.
- Registers the result into a single-entry response slot with valid/ready backpressure.
- Sits between multiple accumulation or compute lanes and the FP32 add resource, so lanes do not each need their own adder.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters. Must be 2 or more.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester index.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous and active-high. Assertion clears all state immediately.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_ready`  out  N_REQ: per-requester accept. At most one bit set per cycle.
- `req_a`  in  N_REQ*32: operand A per requester. Requester i uses bits [32i+31:32i].
- `req_b`  in  N_REQ*32: operand B per requester, same packing as `req_a`.
- `req_op`  in  N_REQ*2: operation per requester. 00 = a+b, 01 = pass a, 10 = pass b, 11 = a-b.
- `rsp_valid`  out  1: response slot holds a result.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  ID_W: index of the requester that owns the response.
- `rsp_data`  out  32: FP32 result.

## Operation

- **Slot free.** `slot_free = ~rsp_valid | rsp_ready`.
- **Grant.** Round-robin over the set `req_valid` bits.
  - Search starts at pointer `ptr` and wraps modulo `N_REQ`.
  - The grant is combinational from `req_valid` and `ptr`.
- **Ready.** `req_ready[i] = grant[i] & slot_free`. A transfer occurs when `req_valid[i] & req_ready[i]`.
- **Operations.**
  - Subtract (op 11): flip bit 31 of B before the adder. This also applies to NaN and zero.
  - Pass ops (01, 10) bypass the adder result. The operand is forwarded bit-exact, including NaN payloads and denormals.
  - Adder rounding and special-value behaviour are exactly those of `fp32adder`; this block does not change them.
- **On transfer from requester i:**
  - `rsp_data` is loaded with the op result.
  - `rsp_id` is loaded with i.
  - `rsp_valid` is set to 1.
  - `ptr` becomes (i+1) mod N_REQ.
- **No new transfer.** If `rsp_valid & rsp_ready` and no new transfer occurs, `rsp_valid` becomes 0. `rsp_data` and `rsp_id` hold their values.
- **Stall.** If `rsp_valid & ~rsp_ready`:
  - `req_ready` is all zero.
  - `rsp_data`, `rsp_id` and `rsp_valid` hold.
  - `ptr` holds.
- **Requester rule.** A requester keeps `req_valid` and its operands stable until it is accepted. If `req_valid` drops before grant, the request is simply never served; there is no error.
- **No valid requests.** If no `req_valid` bit is set, nothing is granted and `ptr` holds.
- **State.** Response register, `rsp_valid`, `ptr`. No other FSM.

## Timing

- Reset values:
  - `rsp_valid` = 0, `rsp_data` = 32'h0, `rsp_id` = 0, `ptr` = 0.
  - `req_ready` = 0 while `rst` is high.
- Latency: accept in cycle T gives `rsp_valid` = 1 with the result in cycle T+1.
- Throughput: one result per cycle while `rsp_ready` stays 1.
- Drain and refill in the same cycle: with a full slot, `rsp_ready` = 1 and a pending request, the slot is drained and refilled in the same edge. There is no bubble.
- Reset mid-operation: any held response is discarded. No transfer is reported for a request whose handshake coincides with the reset assertion.
- Fairness: with all requesters continuously valid, each is served once every `N_REQ` accepted transfers.

## Structure

- Shared package `fp_pkg` holds:
  - the `FP32_W` = 32 constant;
  - the op encodings `OP_ADD`, `OP_PASS_A`, `OP_PASS_B`, `OP_SUB`;
  - the sign-bit index constant.
- Sub-module `rr_arb` (parameter N):
  - inputs `req[N]` and `ptr`; outputs a one-hot `grant` and the encoded `grant_id`;
  - purely combinational, so it can be reused by other shared-datapath blocks.
- The top level instantiates `rr_arb`, one `fp32adder` and the operand/op muxes, and owns the response register and `ptr`.

## Test plan

- **Add.** Requester 0 sends op 00, a = 0x3F800000, b = 0x40000000, with `rsp_ready` = 1. Next cycle: `rsp_valid` = 1, `rsp_id` = 0, `rsp_data` = 0x40400000.
- **Subtract and pass.**
  - Requester 2 sends op 11, a = 0x40400000, b = 0x3F800000. Expect `rsp_data` = 0x40000000, `rsp_id` = 2.
  - Requester 1 sends op 01, a = 0x7FC00001. Expect 0x7FC00001, bit-exact.
- **Fairness.** All 4 requesters valid every cycle with `rsp_ready` = 1. Expect `rsp_id` sequence 0,1,2,3,0,1 on consecutive cycles, and exactly one `req_ready` bit per cycle.
- **Backpressure.** Hold `rsp_ready` = 0 for 5 cycles with a full slot. Expect:
  - `req_ready` = 0 throughout;
  - `rsp_data` and `rsp_id` stable;
  - after `rsp_ready` rises, the next grant goes to `ptr` with no lost or duplicated response.
- **Sparse and wrap.** Only requester 3 is valid, then only requester 0. Expect grants 3 then 0, with `ptr` wrapping to 0 and then to 1.
- **Reset mid-operation.** Assert `rst` asynchronously while `rsp_valid` = 1. Expect `rsp_valid`, `rsp_data`, `rsp_id` and `ptr` to go to 0 immediately, before the next clock edge, and the first grant after release to go to requester 0.
